// File: rtl/pq_arbiter_pkg.sv
// Shared types for the priority-queue arbiter: key-value layout, queue
// operation codes and the arbiter FSM state encoding.
package pq_arbiter_pkg;

  localparam int KEY_W = 8;
  localparam int VAL_W = 8;
  localparam int KV_W  = KEY_W + VAL_W;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_ENQ     = 2'd1,
    OP_DEQ     = 2'd2,
    OP_REPLACE = 2'd3
  } pq_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } pq_arb_state_t;

endpackage

// File: rtl/pq_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Returns a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] id
);

  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    gnt     = '0;
    id      = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = ID_W'((int'(ptr) + i) % N);
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        id         = w_idx;
      end
    end
  end

endmodule

// File: rtl/pq_arbiter.sv
// Round-robin front end sharing one priority queue between NREQ ports;
// one transaction in flight, with an occupancy counter.
module pq_arbiter
  import pq_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 16,
  parameter int ID_W  = $clog2(NREQ),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  // Request handshake: a port raises req_valid with op/kv and holds them
  // stable until req_ack pulses for it; the ack cycle ends the request.
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [KV_W*NREQ-1:0] req_kv,
  output logic [NREQ-1:0]      req_ack,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [KV_W-1:0]      rsp_kv,
  output logic                 rsp_err,
  output logic [CNT_W-1:0]     count,
  output logic                 pq_enq,
  output logic                 pq_deq,
  output logic                 pq_replace,
  output logic [KV_W-1:0]      pq_kvi,
  input  logic [KV_W-1:0]      pq_kvo,
  input  logic                 pq_full,
  input  logic                 pq_empty,
  input  logic                 pq_busy,
  output logic [1:0]           dbg_state
);

  pq_arb_state_t   r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  pq_op_t          r_op;
  logic [KV_W-1:0] r_kv;
  logic [KV_W-1:0] r_rsp_kv;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic [CNT_W-1:0] r_count;

  logic [NREQ-1:0] w_gnt;
  logic [ID_W-1:0] w_gnt_id;
  logic [1:0]      w_sel_op;
  logic [KV_W-1:0] w_sel_kv;
  logic            w_legal;
  logic            w_issue;

  rr_arbiter #(.N(NREQ), .ID_W(ID_W)) u_rr (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .id  (w_gnt_id)
  );

  always_comb begin
    w_sel_op = '0;
    w_sel_kv = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_op = req_op[2*i +: 2];
        w_sel_kv = req_kv[KV_W*i +: KV_W];
      end
    end
  end

  // Legality is judged on the queue flags seen in the ISSUE cycle itself.
  always_comb begin
    case (r_op)
      OP_ENQ:             w_legal = !pq_full;
      OP_DEQ, OP_REPLACE: w_legal = !pq_empty;
      default:            w_legal = 1'b0;
    endcase
  end

  assign w_issue    = (r_state == ST_ISSUE) && w_legal;
  assign pq_enq     = w_issue && (r_op == OP_ENQ);
  assign pq_deq     = w_issue && (r_op == OP_DEQ);
  assign pq_replace = w_issue && (r_op == OP_REPLACE);
  assign req_ack    = (r_state == ST_ISSUE) ? (NREQ'(1) << r_id) : '0;

  assign pq_kvi    = r_kv;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_kv    = r_rsp_kv;
  assign rsp_err   = r_rsp_err;
  assign count     = r_count;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_op        <= OP_NOP;
      r_kv        <= '0;
      r_rsp_kv    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if ((|req_valid) && !pq_busy) begin
            r_id      <= w_gnt_id;
            r_op      <= pq_op_t'(w_sel_op);
            r_kv      <= w_sel_kv;
            r_rsp_err <= 1'b0;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_ptr <= (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + ID_W'(1);
          if (w_legal) begin
            r_rsp_kv  <= (r_op == OP_ENQ) ? '0 : pq_kvo;
            r_rsp_err <= 1'b0;
            r_state   <= ST_WAIT;
          end else begin
            r_rsp_kv    <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (!pq_busy) begin
            r_rsp_valid <= 1'b1;
            // Count moves with the response so it is current while rsp_valid is high.
            if (r_op == OP_ENQ && r_count != CNT_W'(DEPTH)) r_count <= r_count + CNT_W'(1);
            if (r_op == OP_DEQ && r_count != '0)            r_count <= r_count - CNT_W'(1);
            r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_arbiter.sv
// Directed bench for pq_arbiter with a behavioural priority queue attached;
// expected acks and responses are queued by stimulus and checked by a monitor.
module tb_pq_arbiter;
  import pq_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [2*NREQ-1:0]    req_op = '0;
  logic [KV_W*NREQ-1:0] req_kv = '0;
  logic [NREQ-1:0]      req_ack;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [KV_W-1:0]      rsp_kv;
  logic                 rsp_err;
  logic [4:0]           count;
  logic                 pq_enq, pq_deq, pq_replace;
  logic [KV_W-1:0]      pq_kvi;
  logic [KV_W-1:0]      pq_kvo = '0;
  logic                 pq_full = 1'b0;
  logic                 pq_empty = 1'b1;
  logic                 pq_busy;
  logic [1:0]           dbg_state;

  pq_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_kv(req_kv),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_kv(rsp_kv),
    .rsp_err(rsp_err), .count(count), .pq_enq(pq_enq), .pq_deq(pq_deq),
    .pq_replace(pq_replace), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo), .pq_full(pq_full),
    .pq_empty(pq_empty), .pq_busy(pq_busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- queue model ----------------
  logic [KV_W-1:0] model_q[$];
  int busy_len = 0;
  int busy_cnt = 0;

  function automatic void model_ins(logic [KV_W-1:0] v);
    int i = 0;
    while (i < model_q.size() && model_q[i][15:8] <= v[15:8]) i++;
    model_q.insert(i, v);
  endfunction

  // The queue raises busy in the strobe cycle and holds it busy_len cycles in total.
  assign pq_busy = (pq_enq | pq_deq | pq_replace) ? (busy_len > 0) : (busy_cnt > 0);

  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
      busy_cnt <= 0;
    end else begin
      if (pq_deq || pq_replace) void'(model_q.pop_front());
      if (pq_enq || pq_replace) model_ins(pq_kvi);
      if (pq_enq || pq_deq || pq_replace) busy_cnt <= (busy_len > 0) ? busy_len - 1 : 0;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    pq_kvo   <= (model_q.size() > 0) ? model_q[0] : '0;
    pq_full  <= (model_q.size() == DEPTH);
    pq_empty <= (model_q.size() == 0);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int n_enq = 0, n_deq = 0, n_rep = 0;
  logic [35:0] ack_q[$];
  logic [55:0] rsp_q[$];
  logic [35:0] ack_e;
  logic [55:0] rsp_e;

  function automatic logic [KV_W-1:0] mk_kv(int key);
    return {8'(key), 8'(key) ^ 8'h5A};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string nm, input logic [63:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0h expected none (cycle %0d)", nm, act, cyc);
  endtask

  function automatic void exp_ack(int c, int port);
    ack_q.push_back({32'(c), 4'(1 << port)});
  endfunction

  function automatic void exp_rsp(int c, int id, int key, logic err, int cnt);
    logic [KV_W-1:0] kv = (key < 0) ? '0 : mk_kv(key);
    rsp_q.push_back({32'(c), 2'(id), kv, err, 5'(cnt)});
  endfunction

  always @(negedge clk) begin
    if (pq_enq) n_enq++;
    if (pq_deq) n_deq++;
    if (pq_replace) n_rep++;
    if (req_ack != '0) begin
      if (ack_q.size() == 0) note_fail("ack_unexpected", 64'(req_ack));
      else begin
        ack_e = ack_q.pop_front();
        check("ack_cycle", 64'(cyc), 64'(ack_e[35:4]));
        check("ack_vec", 64'(req_ack), 64'(ack_e[3:0]));
      end
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) note_fail("rsp_unexpected", 64'(rsp_id));
      else begin
        rsp_e = rsp_q.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(rsp_e[55:24]));
        check("rsp_id", 64'(rsp_id), 64'(rsp_e[23:22]));
        check("rsp_kv", 64'(rsp_kv), 64'(rsp_e[21:6]));
        check("rsp_err", 64'(rsp_err), 64'(rsp_e[5]));
        check("rsp_count", 64'(count), 64'(rsp_e[4:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int port, input pq_op_t op, input int key);
    req_valid[port] = 1'b1;
    req_op[2*port +: 2] = op;
    req_kv[KV_W*port +: KV_W] = mk_kv(key);
  endtask

  task automatic wait_ack(input int port);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ack[port] && n < 60);
    if (!req_ack[port]) note_fail("ack_timeout", 64'(port));
  endtask

  task automatic drain();
    int n = 0;
    while (rsp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0) begin
      note_fail("rsp_timeout", 64'(rsp_q.size()));
      rsp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One request from an idle arbiter; lat is the response cycle offset from drive.
  task automatic single(input int port, input pq_op_t op, input int key, input int busy,
                        input int lat, input int exp_key, input logic err, input int cnt);
    int t;
    busy_len = busy;
    t = cyc;
    drive(port, op, key);
    exp_ack(t + 1, port);
    exp_rsp(t + lat, port, exp_key, err, cnt);
    wait_ack(port);
    req_valid[port] = 1'b0;
    drain();
    busy_len = 0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int t, e0, d0, r0;
    do_reset();
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_count", 64'(count), 64'd0);
    check("rst_ack", 64'(req_ack), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_kv", 64'(rsp_kv), 64'd0);
    check("rst_pq_kvi", 64'(pq_kvi), 64'd0);
    check("rst_strobes", 64'({pq_enq, pq_deq, pq_replace}), 64'd0);

    // Port 1 enqueue, no busy: ack t+1, response t+3.
    e0 = n_enq;
    single(1, OP_ENQ, 5, 0, 3, -1, 1'b0, 1);
    check("t1_enq_strobes", 64'(n_enq - e0), 64'd1);
    check("t1_count", 64'(count), 64'd1);

    // All ports enqueue continuously: grants 0,1,2,3,0 every 4 cycles.
    do_reset();
    t = cyc;
    for (int p = 0; p < NREQ; p++) drive(p, OP_ENQ, 10 + p);
    exp_ack(t + 1, 0);  exp_rsp(t + 3, 0, -1, 1'b0, 1);
    exp_ack(t + 5, 1);  exp_rsp(t + 7, 1, -1, 1'b0, 2);
    exp_ack(t + 9, 2);  exp_rsp(t + 11, 2, -1, 1'b0, 3);
    exp_ack(t + 13, 3); exp_rsp(t + 15, 3, -1, 1'b0, 4);
    exp_ack(t + 17, 0); exp_rsp(t + 19, 0, -1, 1'b0, 5);
    wait_ack(0);
    for (int p = 1; p < NREQ; p++) begin
      wait_ack(p);
      req_valid[p] = 1'b0;
    end
    wait_ack(0);
    req_valid[0] = 1'b0;
    drain();
    check("t2_count", 64'(count), 64'd5);

    // Dequeue from empty: rejected, response at t+2, no strobe.
    do_reset();
    e0 = n_enq; d0 = n_deq; r0 = n_rep;
    single(2, OP_DEQ, 0, 0, 2, -1, 1'b1, 0);
    check("t3_no_strobe", 64'((n_enq - e0) + (n_deq - d0) + (n_rep - r0)), 64'd0);
    check("t3_count", 64'(count), 64'd0);

    // Queue holds 3 and 7; DEQ with busy for 4 cycles from the strobe: response t+6.
    do_reset();
    single(0, OP_ENQ, 7, 0, 3, -1, 1'b0, 1);
    single(0, OP_ENQ, 3, 0, 3, -1, 1'b0, 2);
    d0 = n_deq;
    single(0, OP_DEQ, 0, 4, 6, 3, 1'b0, 1);
    check("t4_deq_strobes", 64'(n_deq - d0), 64'd1);

    // Replace 9 over head 3, then dequeue shows 7 is the new head.
    single(3, OP_ENQ, 3, 0, 3, -1, 1'b0, 2);
    r0 = n_rep;
    single(1, OP_REPLACE, 9, 0, 3, 3, 1'b0, 2);
    check("t5_rep_strobes", 64'(n_rep - r0), 64'd1);
    single(2, OP_DEQ, 0, 0, 3, 7, 1'b0, 1);

    // NOP with valid is rejected.
    single(0, OP_NOP, 0, 0, 2, -1, 1'b1, 1);

    // Fill to DEPTH, then one more ENQ is rejected and count stays at DEPTH.
    do_reset();
    for (int i = 0; i < DEPTH; i++) single(0, OP_ENQ, 20 + i, 0, 3, -1, 1'b0, i + 1);
    e0 = n_enq;
    single(1, OP_ENQ, 99, 0, 2, -1, 1'b1, DEPTH);
    check("t7_full_no_strobe", 64'(n_enq - e0), 64'd0);
    single(0, OP_DEQ, 0, 0, 3, 20, 1'b0, DEPTH - 1);

    // Reset during WAIT drops the response and clears count and pointer.
    busy_len = 5;
    t = cyc;
    drive(2, OP_ENQ, 1);
    exp_ack(t + 1, 2);
    wait_ack(2);
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("t8_in_wait", 64'(dbg_state), 64'(ST_WAIT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    busy_len = 0;
    check("t8_state", 64'(dbg_state), 64'(ST_IDLE));
    check("t8_count", 64'(count), 64'd0);
    check("t8_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (6) @(negedge clk);
    t = cyc;
    drive(0, OP_ENQ, 40);
    drive(3, OP_ENQ, 41);
    exp_ack(t + 1, 0); exp_rsp(t + 3, 0, -1, 1'b0, 1);
    exp_ack(t + 5, 3); exp_rsp(t + 7, 3, -1, 1'b0, 2);
    wait_ack(0);
    req_valid[0] = 1'b0;
    wait_ack(3);
    req_valid[3] = 1'b0;
    drain();

    check("leftover_acks", 64'(ack_q.size()), 64'd0);
    check("leftover_rsps", 64'(rsp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    note_fail("global_timeout", 64'(cyc));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pq_arbiter.md
# pq_arbiter

Shares one hardware priority queue between NREQ requester ports. Accepts enqueue, dequeue and replace requests, picks one per transaction by round-robin, and sequences it into the queue's enq/deq/replace/busy handshake. Returns the dequeued key-value and an error flag to the winning port. Sits between the client logic and a priority-queue instance, and keeps an occupancy count.

## Interface
- NREQ, 4: number of requester ports, 2..8
- DEPTH, 16: queue capacity; must match the attached queue
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NREQ  per-port request pending
- req_op  in  NREQ x pq_op_t  per-port operation (OP_ENQ/OP_DEQ/OP_REPLACE)
- req_kv  in  NREQ x kv_t  per-port key-value for ENQ/REPLACE
- req_ack  out  NREQ  one-hot, one-cycle pulse: request accepted
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  $clog2(NREQ)  port the response belongs to
- rsp_kv  out  kv_t  head value removed by DEQ/REPLACE; 0 for ENQ
- rsp_err  out  1  operation rejected (ENQ when full; DEQ/REPLACE when empty)
- count  out  $clog2(DEPTH+1)  current queue occupancy
- pq_enq, pq_deq, pq_replace  out  1 each  one-cycle operation strobes to queue
- pq_kvi  out  kv_t  data to queue
- pq_kvo  in  kv_t  queue head
- pq_full, pq_empty, pq_busy  in  1 each  queue status

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - if any req_valid and !pq_busy, select winner by round-robin starting at ptr.
  - latch winner id, req_op[winner] and req_kv[winner].
  - go to ISSUE.
- ISSUE:
  - pulse req_ack[winner].
  - set ptr = (winner+1) mod NREQ.
  - legality check uses pq_full/pq_empty in this cycle.
  - legal: pulse the matching pq_* strobe, drive pq_kvi = latched kv, capture pq_kvo into rsp_kv (DEQ/REPLACE only), go to WAIT.
  - illegal: no strobe, rsp_err set, rsp_kv = 0, go to RESP.
- WAIT: stay at least one cycle; exit to RESP in the first cycle with pq_busy=0.
- RESP:
  - pulse rsp_valid with rsp_id/rsp_kv/rsp_err.
  - update count on legal ops: ENQ +1, DEQ −1, REPLACE unchanged.
  - go to IDLE.
- Requesters hold req_valid/op/kv stable until req_ack. Deasserting earlier is a protocol violation; behaviour is undefined.
- Only one transaction is in flight; no queueing of requests inside the block.
- req_op value OP_NOP with req_valid=1 is treated as illegal and gets rsp_err=1.

## Timing
- Reset values:
  - state IDLE, ptr 0, count 0.
  - req_ack, rsp_valid, rsp_err, all pq_* strobes 0.
  - rsp_id 0, rsp_kv 0, pq_kvi 0.
- Minimum latency:
  - request sampled in IDLE at t.
  - req_ack and pq strobe at t+1.
  - WAIT at t+2.
  - rsp_valid at t+3.
  - next IDLE at t+4.
- Each cycle pq_busy stays high in WAIT extends latency by one.
- Illegal op: ack at t+1, rsp_valid at t+2.
- All outputs are registered except req_ack and the pq_* strobes, which decode state==ISSUE. Those are glitch-free from registered state.
- IDLE with pq_busy=1: no grant; ptr unchanged.
- Reset mid-transaction: return to IDLE next cycle with reset values; the in-flight response is dropped. The queue shares rst, so count=0 stays consistent.
- count saturates at DEPTH and 0. It never wraps; a legal check prevents this anyway.

## Structure
- pq_pkg additions:
  - typedef enum logic [1:0] pq_op_t {OP_NOP=0, OP_ENQ=1, OP_DEQ=2, OP_REPLACE=3}.
  - kv_t is reused.
- Sub-module rr_arbiter: parameter N; inputs req[N], ptr, output one-hot gnt and encoded id. Purely combinational, reusable by other PQ front-ends.
- FSM, latches, pointer and counter live in pq_arbiter.

## Test plan
- Reset, then port 1 ENQ kv={key 5}, pq_busy never high → req_ack[1] at t+1, rsp_valid at t+3 with rsp_id=1, rsp_err=0; count=1.
- All 4 ports request ENQ continuously → acks in order 0,1,2,3,0; count increments to 5.
- Empty queue, port 2 DEQ → req_ack[2] at t+1, rsp_valid t+2, rsp_err=1, rsp_kv=0, no pq strobe, count stays 0.
- Queue holds keys 3,7, pq_busy held 4 cycles after strobe; port 0 DEQ → rsp_kv key 3 at t+6; count 2→1.
- REPLACE key 9 with head key 3 → rsp_kv key 3, pq_replace one pulse, count unchanged.
- Assert rst during WAIT → next cycle IDLE, rsp_valid never pulses, count=0, ptr=0.
